// File: rtl/gate_pkg.sv
// Shared definitions for the bitwise gate unit: op codes, FSM states and the gate function.
package gate_pkg;

    localparam int GATE_MAX_W = 256;

    typedef enum logic [2:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_NAND = 3'd2,
        OP_NOR  = 3'd3,
        OP_XOR  = 3'd4,
        OP_XNOR = 3'd5,
        OP_NOT  = 3'd6,
        OP_BUF  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // Width-agnostic: callers zero-extend to GATE_MAX_W and truncate the result to their width.
    function automatic logic [GATE_MAX_W-1:0] gate_fn(
        input op_e                   op,
        input logic [GATE_MAX_W-1:0] a,
        input logic [GATE_MAX_W-1:0] b
    );
        logic [GATE_MAX_W-1:0] y;
        case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_NAND: y = ~(a & b);
            OP_NOR:  y = ~(a | b);
            OP_XOR:  y = a ^ b;
            OP_XNOR: y = ~(a ^ b);
            OP_NOT:  y = ~a;
            default: y = a;
        endcase
        return y;
    endfunction

endpackage

// File: rtl/gate_bitwise.sv
// Purely combinational WIDTH-bit gate: y = f(op, a, b).
// No latency, no flow control.
module gate_bitwise
    import gate_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  op_e              i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_y
);

    assign o_y = WIDTH'(gate_fn(i_op, GATE_MAX_W'(i_a), GATE_MAX_W'(i_b)));

endmodule

// File: rtl/logic_gate_unit.sv
// Registered WIDTH-bit bitwise gate with run-time op select and a built-in exhaustive operand sweep.
// One cycle from acceptance to out_valid; the output register holds on !out_ready and in_ready follows it.
module logic_gate_unit
    import gate_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int SWEEP_BITS = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       op,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sweep_start,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic             out_last,
    output logic             busy
);

    localparam int CNT_W = 2 * SWEEP_BITS;

    state_e           r_state;
    logic [CNT_W-1:0] r_cnt;
    op_e              r_sweep_op;
    logic             r_out_en;
    logic             r_out_vld;
    logic [WIDTH-1:0] r_out_y;
    logic [WIDTH-1:0] r_out_a;
    logic [WIDTH-1:0] r_out_b;
    logic             r_out_last;

    logic             w_can_load;
    logic             w_in_sweep;
    logic             w_cnt_max;
    logic             w_norm_issue;
    logic             w_sweep_issue;
    logic             w_issue;
    op_e              w_op_sel;
    logic [WIDTH-1:0] w_a_sel;
    logic [WIDTH-1:0] w_b_sel;
    logic [WIDTH-1:0] w_y;

    assign w_can_load    = !r_out_vld || out_ready;
    assign w_in_sweep    = (r_state == ST_SWEEP);
    assign w_cnt_max     = &r_cnt;
    // r_out_en keeps in_ready low until the first clock after reset release.
    assign in_ready      = r_out_en && (r_state == ST_IDLE) && !sweep_start && w_can_load;
    assign w_norm_issue  = in_valid && in_ready;
    assign w_sweep_issue = w_in_sweep && w_can_load;
    assign w_issue       = w_norm_issue || w_sweep_issue;

    assign w_op_sel = w_in_sweep ? r_sweep_op : op_e'(op);
    assign w_a_sel  = w_in_sweep ? WIDTH'(r_cnt[CNT_W-1:SWEEP_BITS]) : a;
    assign w_b_sel  = w_in_sweep ? WIDTH'(r_cnt[SWEEP_BITS-1:0]) : b;

    gate_bitwise #(
        .WIDTH (WIDTH)
    ) u_gate (
        .i_op (w_op_sel),
        .i_a  (w_a_sel),
        .i_b  (w_b_sel),
        .o_y  (w_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_sweep_op <= OP_AND;
            r_out_en   <= 1'b0;
            r_out_vld  <= 1'b0;
            r_out_y    <= '0;
            r_out_a    <= '0;
            r_out_b    <= '0;
            r_out_last <= 1'b0;
        end else begin
            r_out_en <= 1'b1;

            if (w_issue) begin
                r_out_vld  <= 1'b1;
                r_out_y    <= w_y;
                r_out_a    <= w_a_sel;
                r_out_b    <= w_b_sel;
                r_out_last <= w_sweep_issue && w_cnt_max;
            end else if (out_ready) begin
                r_out_vld  <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (sweep_start) begin
                        r_state    <= ST_SWEEP;
                        r_sweep_op <= op_e'(op);
                        r_cnt      <= '0;
                    end
                end
                ST_SWEEP: begin
                    // The all-ones beat ends the pass; the counter is left there rather than wrapped.
                    if (w_sweep_issue) begin
                        if (w_cnt_max) begin
                            r_state <= ST_DRAIN;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (r_out_vld && out_ready && r_out_last) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign out_valid = r_out_vld;
    assign out_y     = r_out_y;
    assign out_a     = r_out_a;
    assign out_b     = r_out_b;
    assign out_last  = r_out_last;
    assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_logic_gate_unit.sv
// Scoreboard bench for logic_gate_unit: one instance with SWEEP_BITS=1 and one with SWEEP_BITS=2 share stimulus.
module tb_logic_gate_unit;

    typedef logic [24:0] beat_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] op;
    logic       in_valid;
    logic [7:0] a;
    logic [7:0] b;
    logic       sweep_start;
    logic       out_ready;

    logic [1:0]      in_ready_w;
    logic [1:0]      out_valid_w;
    logic [1:0]      out_last_w;
    logic [1:0]      busy_w;
    logic [1:0][7:0] out_y_w;
    logic [1:0][7:0] out_a_w;
    logic [1:0][7:0] out_b_w;

    int    n_cmp = 0;
    int    n_err = 0;
    beat_t q0[$];
    beat_t q1[$];
    bit    rand_rdy = 1'b0;

    logic [7:0] y_f0cc [8] = '{8'hC0, 8'hFC, 8'h3F, 8'h03, 8'h3C, 8'hC3, 8'h0F, 8'hF0};
    logic [7:0] y_a50f [8] = '{8'h05, 8'hAF, 8'hFA, 8'h50, 8'hAA, 8'h55, 8'h5A, 8'hA5};

    always #5 clk = ~clk;

    logic_gate_unit #(.WIDTH(8), .SWEEP_BITS(1)) u_dut_s1 (
        .clk(clk), .rst_n(rst_n), .op(op), .in_valid(in_valid), .in_ready(in_ready_w[0]),
        .a(a), .b(b), .sweep_start(sweep_start), .out_valid(out_valid_w[0]), .out_ready(out_ready),
        .out_y(out_y_w[0]), .out_a(out_a_w[0]), .out_b(out_b_w[0]), .out_last(out_last_w[0]),
        .busy(busy_w[0])
    );

    logic_gate_unit #(.WIDTH(8), .SWEEP_BITS(2)) u_dut_s2 (
        .clk(clk), .rst_n(rst_n), .op(op), .in_valid(in_valid), .in_ready(in_ready_w[1]),
        .a(a), .b(b), .sweep_start(sweep_start), .out_valid(out_valid_w[1]), .out_ready(out_ready),
        .out_y(out_y_w[1]), .out_a(out_a_w[1]), .out_b(out_b_w[1]), .out_last(out_last_w[1]),
        .busy(busy_w[1])
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: cycle budget expired", name);
    endtask

    function automatic void q_push(input int id, input beat_t v);
        if (id == 0) q0.push_back(v);
        else         q1.push_back(v);
    endfunction

    function automatic int q_size(input int id);
        return (id == 0) ? q0.size() : q1.size();
    endfunction

    function automatic beat_t q_pop(input int id);
        return (id == 0) ? q0.pop_front() : q1.pop_front();
    endfunction

    function automatic logic [7:0] ref_gate(input logic [2:0] o, input logic [7:0] x, input logic [7:0] z);
        case (o)
            3'd0:    return x & z;
            3'd1:    return x | z;
            3'd2:    return ~(x & z);
            3'd3:    return ~(x | z);
            3'd4:    return x ^ z;
            3'd5:    return ~(x ^ z);
            3'd6:    return ~x;
            default: return x;
        endcase
    endfunction

    // Monitor: pops expected beats on handshakes and checks payload stability while stalled.
    for (genvar g = 0; g < 2; g++) begin : g_mon
        beat_t prev;
        bit    stalled = 1'b0;
        always @(negedge clk) begin
            beat_t act;
            act = {out_y_w[g], out_a_w[g], out_b_w[g], out_last_w[g]};
            if (!rst_n) begin
                stalled = 1'b0;
            end else begin
                if (stalled)
                    check($sformatf("hold_dut%0d", g), {out_valid_w[g], act}, {1'b1, prev});
                if (out_valid_w[g] && out_ready) begin
                    if (q_size(g) == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_beat_dut%0d: got %h, expected no beat", g, act);
                    end else begin
                        check($sformatf("beat_dut%0d", g), act, q_pop(g));
                    end
                end
                stalled = out_valid_w[g] && !out_ready;
                prev    = act;
            end
        end
    end

    always begin
        @(posedge clk);
        #1;
        out_ready = rand_rdy ? ($urandom_range(0, 1) == 1) : 1'b1;
    end

    task automatic check_reset(input string tag);
        check({tag, "_out_valid"}, out_valid_w, 0);
        check({tag, "_in_ready"}, in_ready_w, 0);
        check({tag, "_busy"}, busy_w, 0);
        check({tag, "_out_last"}, out_last_w, 0);
        check({tag, "_payload"}, {out_y_w, out_a_w, out_b_w}, 0);
    endtask

    task automatic send(input logic [2:0] o, input logic [7:0] x, input logic [7:0] z, input logic [7:0] ey);
        int k = 0;
        op = o; a = x; b = z; in_valid = 1'b1;
        do begin
            @(negedge clk);
            k++;
        end while (in_ready_w != 2'b11 && k < 50);
        if (in_ready_w != 2'b11) begin
            timeout("send_in_ready");
        end else begin
            q_push(0, {ey, x, z, 1'b0});
            q_push(1, {ey, x, z, 1'b0});
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int k = 0;
        while (out_valid_w != 0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (out_valid_w != 0) timeout("drain");
        @(posedge clk);
        #1;
    endtask

    // y4 holds the hand-computed SWEEP_BITS=1 results, beat 0 in the low byte.
    task automatic run_sweep(input logic [2:0] sop, input logic [31:0] y4, input int abort_k,
                             input int exp_busy0, input int exp_busy1);
        int n0, n1, k, b0, b1;
        logic [7:0] ea, eb;
        n0 = (abort_k > 0) ? 2 : 4;
        n1 = (abort_k > 0) ? 2 : 16;
        for (int i = 0; i < n0; i++) q_push(0, {y4[i*8 +: 8], 8'(i >> 1), 8'(i & 1), (i == 3)});
        for (int i = 0; i < n1; i++) begin
            ea = 8'(i >> 2);
            eb = 8'(i & 3);
            q_push(1, {ref_gate(sop, ea, eb), ea, eb, (i == 15)});
        end
        op = sop; a = 8'h55; b = 8'h33; in_valid = 1'b1; sweep_start = 1'b1;
        @(negedge clk);
        check("collision_in_ready", in_ready_w, 0);
        @(posedge clk);
        #1;
        sweep_start = 1'b0; in_valid = 1'b0; op = ~sop;
        k = 0; b0 = 0; b1 = 0;
        while (k < 1000) begin
            @(negedge clk);
            k++;
            if (busy_w[0]) b0++;
            if (busy_w[1]) b1++;
            if (k == 1) sweep_start = 1'b1;
            if (k == 2) sweep_start = 1'b0;
            if (k == abort_k) begin
                #2 rst_n = 1'b0;
                return;
            end
            if (busy_w == 0) break;
        end
        if (busy_w != 0) timeout("sweep_busy");
        if (exp_busy0 > 0) begin
            check("busy_cycles_s1", b0, exp_busy0);
            check("busy_cycles_s2", b1, exp_busy1);
        end
        wait_drain();
    endtask

    initial begin
        rst_n = 1'b0; op = 3'd0; in_valid = 1'b0; a = 8'h00; b = 8'h00;
        sweep_start = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_reset("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("in_ready_after_release", in_ready_w, 2'b11);

        for (int i = 0; i < 8; i++) send(3'(i), 8'hF0, 8'hCC, y_f0cc[i]);
        wait_drain();

        rand_rdy = 1'b1;
        for (int i = 0; i < 8; i++) send(3'(i), 8'hA5, 8'h0F, y_a50f[i]);
        wait_drain();
        rand_rdy = 1'b0;
        @(posedge clk);
        #1;

        run_sweep(3'd2, 32'hFEFF_FFFF, 0, 5, 17);

        rand_rdy = 1'b1;
        run_sweep(3'd4, 32'h0001_0100, 0, 0, 0);
        rand_rdy = 1'b0;
        @(posedge clk);
        #1;

        run_sweep(3'd0, 32'h0100_0000, 3, 0, 0);
        #1;
        check_reset("abort");
        check("abort_leftover_s1", q0.size(), 0);
        check("abort_leftover_s2", q1.size(), 0);
        q0.delete();
        q1.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("in_ready_after_abort", in_ready_w, 2'b11);

        run_sweep(3'd0, 32'h0100_0000, 0, 5, 17);

        check("final_queue_s1", q0.size(), 0);
        check("final_queue_s2", q1.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d compared / %0d mismatched", n_cmp, n_err);
        $fatal(1, "watchdog expired");
    end

endmodule
